// File: rtl/flt_reduce.sv
// Streaming FP32 min/max reducer: folds one element per cycle and presents min, max, count and NaN flag per packet.
// Optional FLT_REDUCE_ARGIDX_EN adds out_min_idx/out_max_idx giving the packet position of the selected elements.
//
// state   | meaning
// S_EMPTY | no non-NaN element held yet for the current packet
// S_ACC   | min/max registers hold valid data
// S_DONE  | result presented, waiting for out_ready
module flt_reduce #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_min,
  output logic [31:0]      out_max,
  output logic [CNT_W-1:0] out_count,
`ifdef FLT_REDUCE_ARGIDX_EN
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
`endif
  output logic             out_nan
);

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [31:0]      min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             nan_q, nan_d;
`ifdef FLT_REDUCE_ARGIDX_EN
  logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
`endif

  logic accept;
  logic in_is_nan;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Same ordering predicate as the FPU less-than comparator; +0 and -0 are equal.
  function automatic logic lt(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if (is_nan(a) || is_nan(b))
      res = 1'b0;
    else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
      res = 1'b0;
    else if (a[31] != b[31])
      res = a[31];
    else if (!a[31])
      res = a[30:0] < b[30:0];
    else
      res = a[30:0] > b[30:0];
    return res;
  endfunction

  assign accept    = in_valid & in_ready;
  assign in_is_nan = is_nan(in_data);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (accept && in_last)         state_d = S_DONE;
        else if (accept && !in_is_nan) state_d = S_ACC;
      end
      S_ACC: begin
        if (accept && in_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    nan_d   = nan_q;
`ifdef FLT_REDUCE_ARGIDX_EN
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
`endif
    if (accept) begin
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_ONE;
      if (in_is_nan) begin
        nan_d = 1'b1;
      end else if (state_q == S_EMPTY) begin
        min_d = in_data;
        max_d = in_data;
`ifdef FLT_REDUCE_ARGIDX_EN
        min_idx_d = count_q;
        max_idx_d = count_q;
`endif
      end else begin
        if (lt(in_data, min_q)) begin
          min_d = in_data;
`ifdef FLT_REDUCE_ARGIDX_EN
          min_idx_d = count_q;
`endif
        end
        if (lt(max_q, in_data)) begin
          max_d = in_data;
`ifdef FLT_REDUCE_ARGIDX_EN
          max_idx_d = count_q;
`endif
        end
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      min_d   = QNAN;
      max_d   = QNAN;
      count_d = '0;
      nan_d   = 1'b0;
`ifdef FLT_REDUCE_ARGIDX_EN
      min_idx_d = '0;
      max_idx_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q   <= QNAN;
      max_q   <= QNAN;
      count_q <= '0;
      nan_q   <= 1'b0;
`ifdef FLT_REDUCE_ARGIDX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
      nan_q   <= nan_d;
`ifdef FLT_REDUCE_ARGIDX_EN
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
`endif
    end
  end

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;
  assign out_nan   = nan_q;
`ifdef FLT_REDUCE_ARGIDX_EN
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
`endif

endmodule
